// File: rtl/sel_decoder.sv
// Registered 2-bit code to one-hot select decoder; each valid select is held for HOLD_CYCLES cycles.
// Optional SEL_DEC_STICKY_ERR_EN: err stays set until err_clr, otherwise err is a one-cycle pulse.
module sel_decoder #(
  parameter int HOLD_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] code,
  input  logic       code_valid,
  output logic       code_ready,
  output logic       sel1,
  output logic       sel2,
  output logic       sel3,
  output logic       sel_valid,
  output logic       err,
  input  logic       err_clr
);

  localparam int CNT_W = $clog2(HOLD_CYCLES) + 1;
  localparam logic [CNT_W-1:0] LP_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] LP_ONE  = CNT_W'(1);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_sel;
  logic             r_sel_valid;
  logic             r_err;

  logic [2:0]       w_sel_dec;
  logic             w_bad;
  logic             w_accept;

  always_comb begin
    w_sel_dec = 3'b000;
    case (code)
      2'b00:   w_sel_dec = 3'b100;
      2'b01:   w_sel_dec = 3'b010;
      2'b10:   w_sel_dec = 3'b001;
      default: w_sel_dec = 3'b000;
    endcase
  end

  assign w_bad = (code == 2'b11);

  // The last HOLD cycle (cnt==0) accepts a new code so back-to-back selects have no gap.
  assign code_ready = !rst && ((r_state == IDLE) || ((r_state == HOLD) && (r_cnt == '0)));
  assign w_accept   = code_valid && code_ready;

`ifndef SEL_DEC_STICKY_ERR_EN
  logic w_unused_err_clr;
  assign w_unused_err_clr = err_clr;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_sel       <= 3'b000;
      r_sel_valid <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      if (w_accept) begin
        if (w_bad) begin
          r_state     <= IDLE;
          r_cnt       <= '0;
          r_sel       <= 3'b000;
          r_sel_valid <= 1'b0;
        end else begin
          r_state     <= HOLD;
          r_cnt       <= LP_LOAD;
          r_sel       <= w_sel_dec;
          r_sel_valid <= 1'b1;
        end
      end else if (r_state == HOLD) begin
        if (r_cnt != '0) begin
          r_cnt <= r_cnt - LP_ONE;
        end else begin
          r_state     <= IDLE;
          r_sel       <= 3'b000;
          r_sel_valid <= 1'b0;
        end
      end

`ifdef SEL_DEC_STICKY_ERR_EN
      if (w_accept && w_bad) begin
        r_err <= 1'b1;
      end else if (err_clr) begin
        r_err <= 1'b0;
      end
`else
      r_err <= w_accept && w_bad;
`endif
    end
  end

  assign sel1      = r_sel[2];
  assign sel2      = r_sel[1];
  assign sel3      = r_sel[0];
  assign sel_valid = r_sel_valid;
  assign err       = r_err;

endmodule

// File: tb/tb_sel_decoder.sv
// Table-driven bench for sel_decoder (HOLD_CYCLES=4) with a queue scoreboard of per-cycle expectations.
// Error expectations follow SEL_DEC_STICKY_ERR_EN when it is defined for the build.
module tb_sel_decoder;

  localparam int HOLD = 4;
`ifdef SEL_DEC_STICKY_ERR_EN
  localparam logic STICKY = 1'b1;
`else
  localparam logic STICKY = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] code;
  logic       code_valid;
  logic       code_ready;
  logic       sel1, sel2, sel3;
  logic       sel_valid;
  logic       err;
  logic       err_clr;

  always #5 clk = ~clk;

  sel_decoder #(.HOLD_CYCLES(HOLD)) dut (
    .clk        (clk),
    .rst        (rst),
    .code       (code),
    .code_valid (code_valid),
    .code_ready (code_ready),
    .sel1       (sel1),
    .sel2       (sel2),
    .sel3       (sel3),
    .sel_valid  (sel_valid),
    .err        (err),
    .err_clr    (err_clr)
  );

  // Inputs for one cycle plus the outputs expected just after that cycle's rising edge.
  typedef struct packed {
    logic [1:0] code;
    logic       vld;
    logic       clr;
    logic [2:0] sel;
    logic       sv;
    logic       rdy;
    logic       err;
  } vec_t;

  vec_t vecs[$];
  vec_t sbq[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [2:0] act, input logic [2:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic [9:0] bits);
    vecs.push_back(vec_t'(bits));
  endtask

  task automatic run_table(input string tag);
    foreach (vecs[i]) begin
      vec_t v;
      vec_t e;
      v = vecs[i];
      @(negedge clk);
      code       = v.code;
      code_valid = v.vld;
      err_clr    = v.clr;
      sbq.push_back(v);
      @(posedge clk);
      #1;
      e = sbq.pop_front();
      check($sformatf("%s[%0d] sel", tag, i), {sel1, sel2, sel3}, e.sel);
      check($sformatf("%s[%0d] sel_valid", tag, i), 3'(sel_valid), 3'(e.sv));
      check($sformatf("%s[%0d] code_ready", tag, i), 3'(code_ready), 3'(e.rdy));
      check($sformatf("%s[%0d] err", tag, i), 3'(err), 3'(e.err));
    end
    vecs.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst        = 1'b1;
    code       = 2'b00;
    code_valid = 1'b0;
    err_clr    = 1'b0;

    #3;
    check("reset sel", {sel1, sel2, sel3}, 3'b000);
    check("reset sel_valid", 3'(sel_valid), 3'b000);
    check("reset code_ready", 3'(code_ready), 3'b000);
    check("reset err", 3'(err), 3'b000);
    code_valid = 1'b1;
    code       = 2'b01;
    @(posedge clk);
    #1;
    check("reset held sel", {sel1, sel2, sel3}, 3'b000);
    check("reset held code_ready", 3'(code_ready), 3'b000);
    @(negedge clk);
    code_valid = 1'b0;
    rst        = 1'b0;
    #1;
    check("post-reset code_ready", 3'(code_ready), 3'b001);

    // Fields: code_vld_clr_sel_sv_rdy_err
    add(10'b01_1_0_010_1_0_0);
    add(10'b01_0_0_010_1_0_0);
    add(10'b01_0_0_010_1_0_0);
    add(10'b01_0_0_010_1_1_0);
    add(10'b01_0_0_000_0_1_0);
    run_table("single");

    for (int k = 0; k < 3; k++) begin
      logic [1:0] c;
      logic [2:0] s;
      c = (k == 0) ? 2'b00 : (k == 1) ? 2'b10 : 2'b01;
      s = (k == 0) ? 3'b100 : (k == 1) ? 3'b001 : 3'b010;
      for (int j = 0; j < HOLD; j++) begin
        add({c, 1'b1, 1'b0, s, 1'b1, (j == HOLD - 1), 1'b0});
      end
    end
    add(10'b00_0_0_000_0_1_0);
    run_table("stream");

    add(10'b11_1_0_000_0_1_1);
    add({2'b00, 1'b0, 1'b0, 3'b000, 1'b0, 1'b1, STICKY});
    add({2'b00, 1'b0, 1'b0, 3'b000, 1'b0, 1'b1, STICKY});
    add(10'b00_0_1_000_0_1_0);
    add(10'b11_1_1_000_0_1_1);
    add(10'b00_0_1_000_0_1_0);
    add(10'b00_0_0_000_0_1_0);
    run_table("err_idle");

    add(10'b00_1_0_100_1_0_0);
    add(10'b00_0_0_100_1_0_0);
    add(10'b00_0_0_100_1_0_0);
    add(10'b00_0_0_100_1_1_0);
    add(10'b11_1_0_000_0_1_1);
    add(10'b00_0_1_000_0_1_0);
    run_table("err_last");

    add(10'b01_1_0_010_1_0_0);
    add(10'b10_1_0_010_1_0_0);
    add(10'b00_0_0_010_1_0_0);
    add(10'b11_1_0_010_1_1_0);
    add(10'b11_0_0_000_0_1_0);
    add(10'b00_0_0_000_0_1_0);
    run_table("toggle");

    // Asynchronous reset in the second HOLD cycle of code 2'b10.
    @(negedge clk);
    code       = 2'b10;
    code_valid = 1'b1;
    @(posedge clk);
    #1;
    check("arst accept sel", {sel1, sel2, sel3}, 3'b001);
    @(negedge clk);
    code_valid = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("arst sel", {sel1, sel2, sel3}, 3'b000);
    check("arst sel_valid", 3'(sel_valid), 3'b000);
    check("arst code_ready", 3'(code_ready), 3'b000);
    check("arst err", 3'(err), 3'b000);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("arst release code_ready", 3'(code_ready), 3'b001);

    add(10'b00_1_0_100_1_0_0);
    add(10'b00_0_0_100_1_0_0);
    add(10'b00_0_0_100_1_0_0);
    add(10'b00_0_0_100_1_1_0);
    add(10'b00_0_0_000_0_1_0);
    run_table("post_arst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sel_decoder.md
# sel_decoder

Registered 2-bit-code to one-hot select decoder: the inverse of the team's 3-input select encoder. It accepts a code over a valid/ready handshake, drives the matching one-hot select onto `sel1`/`sel2`/`sel3` for a fixed number of cycles, then releases it. It sits between the control logic that produces a compact select code and the datapath muxes that consume one-hot selects.

## Interface
- `HOLD_CYCLES`, default 4: cycles each valid select is held; legal range 1..255.
- `clk` input 1: clock; all state updates on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `code` input 2: select code; sampled only on handshake.
- `code_valid` input 1: `code` is valid.
- `code_ready` output 1: decoder can accept a code this cycle.
- `sel1` output 1: one-hot select bit for code 2'b00.
- `sel2` output 1: one-hot select bit for code 2'b01.
- `sel3` output 1: one-hot select bit for code 2'b10.
- `sel_valid` output 1: a select is currently being driven.
- `err` output 1: an invalid code (2'b11) was accepted.
- `err_clr` input 1: clears sticky `err`; ignored unless `SEL_DEC_STICKY_ERR_EN` is defined.

## Operation
- Decode map: 2'b00 -> {sel1,sel2,sel3}=3'b100; 2'b01 -> 3'b010; 2'b10 -> 3'b001; 2'b11 -> invalid, 3'b000.
- FSM states: IDLE, HOLD. Down-counter `cnt`, width $clog2(HOLD_CYCLES)+1.
- Handshake: a code is accepted on a rising edge where `code_valid && code_ready`.
- `code_ready` = (state==IDLE) || (state==HOLD && cnt==0); combinational from registered state, forced 0 while `rst` is high.
- IDLE + valid code accepted -> HOLD, select loaded, `cnt` = HOLD_CYCLES-1.
- HOLD, cnt!=0 -> `cnt` decrements; select unchanged; `code`/`code_valid` ignored.
- HOLD, cnt==0, no acceptance -> IDLE, select 3'b000, `sel_valid` 0.
- HOLD, cnt==0, valid code accepted -> stays HOLD, new select loaded, `cnt` reloaded (back-to-back, no gap cycle).
- Invalid code accepted, from either state -> IDLE, select 3'b000, `sel_valid` 0, error raised.
- Outputs are registered; `sel_valid` is 1 exactly when the select is nonzero.
- Reset: asynchronous. State IDLE, `cnt` 0, `sel1`/`sel2`/`sel3` 0, `sel_valid` 0, `err` 0, `code_ready` 0 while asserted. Reset mid-HOLD aborts the select immediately. Once released, IDLE gives `code_ready` 1.

## Timing
- Latency: a code accepted at edge N drives its select from edge N to edge N+HOLD_CYCLES, i.e. exactly HOLD_CYCLES cycles.
- Throughput: one code per HOLD_CYCLES cycles when back-to-back; one code per cycle is never possible unless HOLD_CYCLES=1.
- With HOLD_CYCLES=1: `code_ready` is constantly 1 out of reset; each accepted code holds for one cycle.
- Without the macro, `err` is a single-cycle pulse in the cycle after an invalid code is accepted.

## Configuration
- `SEL_DEC_STICKY_ERR_EN` defined: `err` sets on an accepted invalid code and holds until a cycle with `err_clr`=1, which clears it on the next edge. If set and clear happen in the same cycle, set wins.
- Not defined: `err` is a one-cycle pulse and `err_clr` has no effect.

## Test plan
All scenarios use HOLD_CYCLES=4.
- Reset, then code=2'b01 with valid for one cycle -> sel=3'b010 and `sel_valid`=1 for 4 cycles, then 3'b000; `code_ready` 0 for 3 cycles, then 1.
- Codes 2'b00, 2'b10 and 2'b01 streamed with `code_valid` held high -> sel 3'b100 ×4, 3'b001 ×4, 3'b010 ×4 with no gap cycles; 3 acceptances in 12 cycles.
- code=2'b11 accepted in IDLE -> sel stays 3'b000, `sel_valid` 0. Without macro, `err`=1 for one cycle. With macro, `err` stays 1 until `err_clr`, clearing one edge later.
- code=2'b11 accepted on the last HOLD cycle of 2'b00 -> next cycle sel=3'b000, state IDLE, `err` asserted.
- `rst` pulsed asynchronously in the second HOLD cycle of code 2'b10 -> all outputs 0 immediately, without a clock edge; after release, `code_ready`=1 and a new 2'b00 decodes normally.
- `code_valid` toggled during HOLD with cnt!=0 -> ignored; the select is unchanged and no extra acceptance occurs.
